// File: rtl/swd_line_monitor_pkg.sv
// Shared types and constants for the SWD line monitor.
// Holds the FSM state encoding, the run counter width and the default select sequence.
package swd_line_monitor_pkg;

  localparam int RUN_W = 7;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [15:0] SWITCH_SEQ_DEFAULT = 16'hE79E;

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_LRESET = 2'd1,
    ST_SEQ    = 2'd2,
    ST_SYNCED = 2'd3
  } swd_state_e;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/swd_line_monitor_run_counter.sv
// Saturating run-length counter of identical SWDIO samples.
// Also exposes the length the run will have after the current sample.
module swd_run_counter
  import swd_line_monitor_pkg::*;
(
  input  logic             i_sck,
  input  logic             i_rst_n,
  input  logic             i_sample,
  input  logic             i_sample_en,
  output logic [RUN_W-1:0] o_run_len,
  output logic [RUN_W-1:0] o_run_next
);

  logic             r_prev;
  logic [RUN_W-1:0] r_run_len;
  logic [RUN_W-1:0] w_run_next;

  // After reset the count is 0 and prev is 0, so the first sample lands on 1 either way.
  always_comb begin
    w_run_next = (i_sample != r_prev) ? RUN_W'(1) : sat_inc(r_run_len);
  end

  always_ff @(posedge i_sck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev    <= 1'b0;
      r_run_len <= '0;
    end else if (i_sample_en) begin
      r_prev    <= i_sample;
      r_run_len <= w_run_next;
    end
  end

  assign o_run_len  = r_run_len;
  assign o_run_next = w_run_next;

endmodule

// File: rtl/swd_line_monitor.sv
// SWD line monitor: detects line resets, the JTAG-to-SWD select sequence and bus idle.
// The FSM and the select-sequence shift register live here; run counting is in swd_run_counter.
module swd_line_monitor
  import swd_line_monitor_pkg::*;
#(
  parameter int          MIN_RESET_ONES = 50,
  parameter int          MIN_IDLE_ZEROS = 50,
  parameter logic [15:0] SWITCH_SEQ     = SWITCH_SEQ_DEFAULT
) (
  input  logic             i_sck,
  input  logic             i_rst_n,
  input  logic             i_swdio_in,
  input  logic             i_sample_en,
  output logic             o_line_reset,
  output logic             o_jtag2swd,
  output logic             o_synced,
  output logic             o_idle,
  output logic [1:0]       o_state,
  output logic [RUN_W-1:0] o_run_len
);

  localparam logic [RUN_W-1:0] RESET_CNT = RUN_W'(MIN_RESET_ONES);
  localparam logic [RUN_W-1:0] IDLE_CNT  = RUN_W'(MIN_IDLE_ZEROS);

  swd_state_e       r_state;
  logic [15:0]      r_shift;
  logic [3:0]       r_bit_cnt;
  logic             r_line_reset;
  logic             r_jtag2swd;
  logic             r_synced;
  logic             r_idle;

  logic [RUN_W-1:0] w_run_len;
  logic [RUN_W-1:0] w_run_next;
  logic             w_lr_hit;
  logic             w_seq_last;
  logic             w_seq_match;
  logic [15:0]      w_seq_word;
  logic             w_idle_next;

  swd_run_counter u_run_counter (
    .i_sck       (i_sck),
    .i_rst_n     (i_rst_n),
    .i_sample    (i_swdio_in),
    .i_sample_en (i_sample_en),
    .o_run_len   (w_run_len),
    .o_run_next  (w_run_next)
  );

  // Only the exact crossing fires, so a long ones run pulses line_reset once.
  assign w_lr_hit    = i_swdio_in && (w_run_next == RESET_CNT);
  assign w_seq_word  = {i_swdio_in, r_shift[14:0]};
  assign w_seq_last  = (r_state == ST_SEQ) && (r_bit_cnt == 4'd15);
  assign w_seq_match = w_seq_last && (w_seq_word == SWITCH_SEQ);

  // A zero sample can never be a line reset, so the next state is SEQ/SYNCED unless the sequence matches.
  assign w_idle_next = !i_swdio_in && (w_run_next >= IDLE_CNT) &&
                       ((r_state == ST_SYNCED) || (r_state == ST_LRESET) ||
                        ((r_state == ST_SEQ) && !w_seq_match));

  always_ff @(posedge i_sck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_UNSYNC;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_line_reset <= 1'b0;
      r_jtag2swd   <= 1'b0;
      r_synced     <= 1'b0;
      r_idle       <= 1'b0;
    end else begin
      r_line_reset <= 1'b0;
      r_jtag2swd   <= 1'b0;
      if (i_sample_en) begin
        r_idle <= w_idle_next;
        if (w_lr_hit) begin
          r_state      <= ST_LRESET;
          r_line_reset <= 1'b1;
          r_shift      <= '0;
          r_bit_cnt    <= '0;
          r_synced     <= 1'b0;
        end else begin
          case (r_state)
            ST_UNSYNC: r_state <= ST_UNSYNC;
            ST_LRESET: begin
              if (!i_swdio_in) begin
                r_state   <= ST_SEQ;
                r_shift   <= '0;
                r_bit_cnt <= 4'd1;
              end
            end
            ST_SEQ: begin
              if (w_seq_last) begin
                r_shift   <= w_seq_word;
                r_bit_cnt <= '0;
                if (w_seq_match) begin
                  r_jtag2swd <= 1'b1;
                  r_state    <= ST_UNSYNC;
                end else begin
                  r_state  <= ST_SYNCED;
                  r_synced <= 1'b1;
                end
              end else begin
                r_shift[r_bit_cnt] <= i_swdio_in;
                r_bit_cnt          <= r_bit_cnt + 4'd1;
              end
            end
            ST_SYNCED: r_state <= ST_SYNCED;
            default:   r_state <= ST_UNSYNC;
          endcase
        end
      end
    end
  end

  assign o_line_reset = r_line_reset;
  assign o_jtag2swd   = r_jtag2swd;
  assign o_synced     = r_synced;
  assign o_idle       = r_idle;
  assign o_state      = r_state;
  assign o_run_len    = w_run_len;

endmodule
